// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module     : debounce_pkg
// Description: Shared types and constants for the push-button debouncer.
//              Key levels are active-low: a pressed key reads 0.
// Revision   : 1.0 - initial release
// ============================================================================
package debounce_pkg;

   // Debouncer FSM: two stable states and one filtering state for each direction
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILT_DN = 2'd1,
      DOWN    = 2'd2,
      FILT_UP = 2'd3
   } state_t;

   // Active-low key levels
   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

   // Number of clock cycles that make up a time window
   function automatic int cycles_for(input int window_ns, input int clk_ns);
      return window_ns / clk_ns;
   endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module     : sync_2ff
// Description: Two-stage synchroniser for a single asynchronous bit. Both
//              stages come out of reset at RST_VAL so the downstream logic
//              sees a defined level from the first cycle after reset.
// Revision   : 1.0 - initial release
// ============================================================================
module sync_2ff
   import debounce_pkg::*;
#(
   parameter logic RST_VAL = KEY_RELEASED
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Shift the raw input through two flops; the first may go metastable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module     : key_debounce
// Description: Debounces one active-low push-button. The raw key is
//              synchronised, then a new level is accepted only after it has
//              been sampled for DEB_CYCLES consecutive cycles. One-cycle
//              press/release strobes accompany each accepted change.
// Revision   : 1.0 - initial release
// ============================================================================
module key_debounce
   import debounce_pkg::*;
#(
   parameter int CLK_CYC = 10,
   parameter int DEB_NS  = 10_000_000
) (
   input  logic sysclk,
   input  logic sysrst,
   input  logic key_in,
   output logic key_out,
   output logic key_press,
   output logic key_release
);

   localparam int DEB_CYCLES = cycles_for(DEB_NS, CLK_CYC);
   localparam int CNT_W      = $clog2(DEB_CYCLES + 1);

   // Count value reached on the last sample of a full window
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic             w_key_s;
   logic             w_cnt_done;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic             r_key_out;
   logic             w_key_out_nxt;
   logic             r_press;
   logic             w_press_nxt;
   logic             r_release;
   logic             w_release_nxt;

   // Bring the raw key into the sysclk domain; idles at the released level
   sync_2ff #(
      .RST_VAL (KEY_RELEASED)
   ) u_sync (
      .clk (sysclk),
      .rst (sysrst),
      .i_d (key_in),
      .o_q (w_key_s)
   );

   // The current sample completes a window when the count already holds
   // DEB_CYCLES-1 earlier samples at the new level
   assign w_cnt_done = (r_cnt == CNT_LAST);

   // State, window counter and registered outputs
   always_ff @(posedge sysclk) begin
      if (sysrst) begin
         r_state   <= IDLE;
         r_cnt     <= CNT_ZERO;
         r_key_out <= KEY_RELEASED;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_key_out <= w_key_out_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Next-state and window counter: any bounce drops back to the stable
   // state, so the window always restarts from the last transition
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_key_s == KEY_PRESSED) begin
               w_state_nxt = FILT_DN;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt   = CNT_ZERO;
            end
         end
         FILT_DN: begin
            if (w_key_s == KEY_RELEASED) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = CNT_ZERO;
            end else if (w_cnt_done) begin
               w_state_nxt = DOWN;
               w_cnt_nxt   = CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         DOWN: begin
            if (w_key_s == KEY_RELEASED) begin
               w_state_nxt = FILT_UP;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt   = CNT_ZERO;
            end
         end
         FILT_UP: begin
            if (w_key_s == KEY_PRESSED) begin
               w_state_nxt = DOWN;
               w_cnt_nxt   = CNT_ZERO;
            end else if (w_cnt_done) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // Output decode: the debounced level and its strobe change together on
   // the edge that completes a window; strobes default low every cycle
   always_comb begin
      w_key_out_nxt = r_key_out;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         FILT_DN: begin
            if ((w_key_s == KEY_PRESSED) && w_cnt_done) begin
               w_key_out_nxt = KEY_PRESSED;
               w_press_nxt   = 1'b1;
            end
         end
         FILT_UP: begin
            if ((w_key_s == KEY_RELEASED) && w_cnt_done) begin
               w_key_out_nxt = KEY_RELEASED;
               w_release_nxt = 1'b1;
            end
         end
         default: begin
            w_key_out_nxt = r_key_out;
         end
      endcase
   end

   assign key_out     = r_key_out;
   assign key_press   = r_press;
   assign key_release = r_release;

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module     : tb_key_debounce
// Description: Self-checking bench for key_debounce with a 100-cycle window.
//              A run-length reference model predicts every output each cycle.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_key_debounce;
   import debounce_pkg::*;

   localparam int CLK_CYC = 10;
   localparam int DEB_NS  = 1000;
   localparam int DEB     = DEB_NS / CLK_CYC;
   localparam int LAT     = DEB + 2;

   logic sysclk = 1'b0;
   logic sysrst = 1'b1;
   logic key_in = 1'b1;
   logic key_out;
   logic key_press;
   logic key_release;

   int checks   = 0;
   int failures = 0;

   // Reference model: a two-deep delay line plus a count of consecutive
   // samples that disagree with the debounced level
   logic m_s1    = 1'b1;
   logic m_s2    = 1'b1;
   logic m_out   = 1'b1;
   logic m_press = 1'b0;
   logic m_rel   = 1'b0;
   int   m_run   = 0;

   key_debounce #(
      .CLK_CYC (CLK_CYC),
      .DEB_NS  (DEB_NS)
   ) dut (
      .sysclk      (sysclk),
      .sysrst      (sysrst),
      .key_in      (key_in),
      .key_out     (key_out),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge
   task automatic model_edge();
      m_press = 1'b0;
      m_rel   = 1'b0;
      if (sysrst) begin
         m_s1  = 1'b1;
         m_s2  = 1'b1;
         m_run = 0;
         m_out = 1'b1;
      end else begin
         if (m_s2 != m_out) m_run++;
         else               m_run = 0;
         if (m_run == DEB) begin
            m_out   = m_s2;
            m_press = (m_s2 == 1'b0);
            m_rel   = (m_s2 == 1'b1);
            m_run   = 0;
         end
         m_s2 = m_s1;
         m_s1 = key_in;
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      model_edge();
      #1;
      chk("key_out", key_out, m_out);
      chk("key_press", key_press, m_press);
      chk("key_release", key_release, m_rel);
      chk("strobe_excl", key_press & key_release, 1'b0);
   endtask

   task automatic hold(input logic v, input int n);
      key_in = v;
      repeat (n) step();
   endtask

   // Apply a level and count cycles until key_out reaches the target
   task automatic measure(input string tag, input logic v, input logic target);
      int n;
      n = 0;
      key_in = v;
      while (key_out !== target && n < 4 * DEB) begin
         step();
         n++;
      end
      chk(tag, n, LAT);
      if (target == 1'b0) chk({tag, "_press"}, key_press, 1'b1);
      else                chk({tag, "_release"}, key_release, 1'b1);
   endtask

   task automatic pulse_reset();
      sysrst = 1'b1;
      step();
      sysrst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      int len;

      // Reset with the key released
      sysrst = 1'b1;
      key_in = 1'b1;
      repeat (3) step();
      sysrst = 1'b0;
      chk("rst_key_out", key_out, 1'b1);
      chk("rst_press", key_press, 1'b0);
      chk("rst_release", key_release, 1'b0);
      chk("rst_state", 32'(dut.r_state), 32'(IDLE));
      hold(1'b1, 5);

      // Clean press held 200 cycles, then clean release
      measure("clean_press_lat", 1'b0, 1'b0);
      hold(1'b0, 200 - LAT);
      chk("clean_held", key_out, 1'b0);
      measure("clean_release_lat", 1'b1, 1'b1);
      hold(1'b1, 10);

      // Bounces shorter than the window never change the output
      hold(1'b0, 50);
      hold(1'b1, 30);
      hold(1'b0, DEB - 1);
      hold(1'b1, 2 * DEB);
      chk("bounce_out", key_out, 1'b1);

      // Bouncy press and bouncy release, toggles at 5/40/70
      hold(1'b1, 5);
      hold(1'b0, 35);
      hold(1'b1, 30);
      measure("bouncy_press_lat", 1'b0, 1'b0);
      hold(1'b0, 10);
      hold(1'b0, 5);
      hold(1'b1, 35);
      hold(1'b0, 30);
      measure("bouncy_release_lat", 1'b1, 1'b1);
      hold(1'b1, 10);

      // Window boundary: one sample short, then exactly a full window
      hold(1'b0, DEB - 1);
      hold(1'b1, 5);
      chk("bound_short_out", key_out, 1'b1);
      hold(1'b1, 20);
      hold(1'b0, DEB);
      hold(1'b1, 5);
      chk("bound_full_out", key_out, 1'b0);
      hold(1'b1, 2 * DEB);
      chk("bound_back_out", key_out, 1'b1);

      // Reset in the middle of a press window while the key stays held
      hold(1'b0, 62);
      pulse_reset();
      chk("midrst_out", key_out, 1'b1);
      measure("midrst_press_lat", 1'b0, 1'b0);
      measure("midrst_release_lat", 1'b1, 1'b1);

      // Random levels with durations clustered around the window edge
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 14) == 0) pulse_reset();
         sel = int'($urandom_range(0, 3));
         if (sel == 0)      len = int'($urandom_range(1, 10));
         else if (sel == 1) len = int'($urandom_range(DEB - 3, DEB + 3));
         else               len = int'($urandom_range(1, 2 * DEB));
         hold(1'($urandom_range(0, 1)), len);
      end
      hold(1'b1, 2 * DEB);
      chk("final_out", key_out, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_key_debounce
`default_nettype wire
